// File: rtl/mips_mem_pkg.sv
// Shared constants and types for the memory responder and its storage array.
// The optional same-address read bypass is enabled by defining MEM_RDBYPASS_EN.
package mips_mem_pkg;

    localparam int unsigned MEM_DEPTH = 1024;
    localparam int unsigned WORD_W    = 32;

    typedef enum logic {
        LOAD,
        RUN
    } mem_state_e;

    // Source of the registered read word presented on rddata
    typedef enum logic [1:0] {
        SelZero,
        SelMem,
        SelByp
    } rd_sel_e;

    function automatic logic addr_in_range(input logic [WORD_W-1:0] a, input int unsigned depth);
        return a < WORD_W'(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array with synchronous, read-first output and no reset,
// so contents survive a responder reset.
module mem_array
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Instruction/data memory front end: loader fills the array in LOAD, then the
// pipeline reads/writes it in RUN. Define MEM_RDBYPASS_EN for write-to-read bypass.
module mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] addr,
    input  logic              wren,
    input  logic [WORD_W-1:0] wrdata,
    output logic [WORD_W-1:0] rddata,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic              run,
    output logic              oob
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrFull = (AW + 1)'(DEPTH);

    mem_state_e        state_q;
    logic [AW:0]       ld_ptr_q;
    logic              ld_ready_q;
    logic              run_q;
    logic              oob_q;
    rd_sel_e           rd_sel_q;

    logic              in_range;
    logic              ld_accept;
    logic              run_wr;
    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [WORD_W-1:0] arr_wdata;
    logic [WORD_W-1:0] arr_rdata;
    logic [AW:0]       ld_ptr_inc;

    assign in_range   = addr_in_range(addr, DEPTH);
    assign ld_accept  = (state_q == LOAD) && ld_valid && ld_ready_q;
    assign run_wr     = (state_q == RUN) && wren && in_range;
    // rst is synchronous, so gating here aborts the write on the reset edge
    assign arr_we     = !rst && (ld_accept || run_wr);
    assign arr_addr   = (state_q == LOAD) ? ld_ptr_q[AW-1:0] : addr[AW-1:0];
    assign arr_wdata  = (state_q == LOAD) ? ld_data : wrdata;
    assign ld_ptr_inc = ld_ptr_q + 1'b1;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            ld_ptr_q   <= '0;
            ld_ready_q <= 1'b1;
            run_q      <= 1'b0;
            oob_q      <= 1'b0;
            rd_sel_q   <= SelZero;
        end else begin
            unique case (state_q)
                LOAD: begin
                    rd_sel_q <= SelZero;
                    if (ld_accept) begin
                        ld_ptr_q   <= ld_ptr_inc;
                        ld_ready_q <= (ld_ptr_inc != PtrFull);
                    end
                    if (ld_done) begin
                        state_q    <= RUN;
                        run_q      <= 1'b1;
                        ld_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (!in_range) begin
                        oob_q    <= 1'b1;
                        rd_sel_q <= SelZero;
                    end else begin
`ifdef MEM_RDBYPASS_EN
                        rd_sel_q <= run_wr ? SelByp : SelMem;
`else
                        rd_sel_q <= SelMem;
`endif
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

`ifdef MEM_RDBYPASS_EN
    logic [WORD_W-1:0] byp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_data_q <= '0;
        end else if (run_wr) begin
            byp_data_q <= wrdata;
        end
    end
`endif

    always_comb begin
        rddata = '0;
        unique case (rd_sel_q)
            SelMem:  rddata = arr_rdata;
`ifdef MEM_RDBYPASS_EN
            SelByp:  rddata = byp_data_q;
`endif
            default: rddata = '0;
        endcase
    end

    assign ld_ready = ld_ready_q;
    assign run      = run_q;
    assign oob      = oob_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with DEPTH=16; expected values are hand-computed.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        ld_done;
    logic        run;
    logic        oob;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wren     (wren),
        .wrdata   (wrdata),
        .rddata   (rddata),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .run      (run),
        .oob      (oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        addr     = '0;
        wren     = 1'b0;
        wrdata   = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_run", {31'b0, run}, 32'h0);
        check("reset_ld_ready", {31'b0, ld_ready}, 32'h1);
        check("reset_oob", {31'b0, oob}, 32'h0);
        check("reset_rddata", rddata, 32'h0);

        // Load four words
        ld_valid = 1'b1;
        ld_data  = 32'h11; tick();
        ld_data  = 32'h22; tick();
        ld_data  = 32'h33; tick();
        ld_data  = 32'h44; tick();
        ld_valid = 1'b0;
        check("load_ready_after4", {31'b0, ld_ready}, 32'h1);
        check("load_rddata_zero", rddata, 32'h0);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        check("run_after_done", {31'b0, run}, 32'h1);
        check("run_ld_ready", {31'b0, ld_ready}, 32'h0);

        addr = 32'd2; tick();
        check("read_addr2", rddata, 32'h33);
        addr = 32'd0; tick();
        check("read_addr0", rddata, 32'h11);
        addr = 32'd3; tick();
        check("read_addr3", rddata, 32'h44);

        // Pipeline write then read back
        addr = 32'd5; wren = 1'b1; wrdata = 32'hDEADBEEF; tick();
        wren = 1'b0; tick();
        check("read_after_write", rddata, 32'hDEADBEEF);
        wren = 1'b1; wrdata = 32'h1; tick();
        wren = 1'b0;
`ifdef MEM_RDBYPASS_EN
        check("same_cycle_rw", rddata, 32'h1);
`else
        check("same_cycle_rw", rddata, 32'hDEADBEEF);
`endif
        tick();
        check("read_new_word", rddata, 32'h1);

        // Out-of-range write aliases to index 0 if the range check is missing
        addr = 32'd16; wren = 1'b1; wrdata = 32'hBAD0BAD0; tick();
        wren = 1'b0;
        check("oob_rddata", rddata, 32'h0);
        check("oob_set", {31'b0, oob}, 32'h1);
        addr = 32'd0; tick();
        check("oob_mem0_kept", rddata, 32'h11);
        check("oob_sticky", {31'b0, oob}, 32'h1);
        ld_valid = 1'b1; ld_data = 32'h77; ld_done = 1'b1; tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        check("run_ignores_loader", {31'b0, run}, 32'h1);
        check("run_ignored_ld_mem0", rddata, 32'h11);

        // Reset in RUN, then pipeline write in LOAD must be ignored
        rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_run", {31'b0, run}, 32'h0);
        check("rst_oob", {31'b0, oob}, 32'h0);
        check("rst_rddata", rddata, 32'h0);
        check("rst_ld_ready", {31'b0, ld_ready}, 32'h1);
        addr = 32'd0; wren = 1'b1; wrdata = 32'hFF; tick();
        wren = 1'b0;
        check("load_rddata_hold", rddata, 32'h0);
        ld_done = 1'b1; tick();
        ld_done = 1'b0;
        addr = 32'd0; tick();
        check("load_wren_ignored", rddata, 32'h11);
        addr = 32'd2; tick();
        check("preserved_addr2", rddata, 32'h33);
        addr = 32'd5; tick();
        check("preserved_addr5", rddata, 32'h1);

        // Offer 17 words into a 16-deep array
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'h100 + i;
            check($sformatf("ld_ready_%0d", i), {31'b0, ld_ready}, (i < 16) ? 32'h1 : 32'h0);
            tick();
        end
        ld_valid = 1'b0;
        check("full_ld_ready", {31'b0, ld_ready}, 32'h0);
        ld_done = 1'b1; tick();
        ld_done = 1'b0;
        addr = 32'd0; tick();
        check("full_word0", rddata, 32'h100);
        addr = 32'd15; tick();
        check("full_word15", rddata, 32'h10F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the array (power of two, 16..65536).
REQ-002 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: addr  input  32  word address from the pipeline, one word per increment.
REQ-005 Port: wren  input  1  pipeline write enable.
REQ-006 Port: wrdata  input  32  pipeline write data.
REQ-007 Port: rddata  output  32  registered read data.
REQ-008 Port: ld_valid  input  1  program-loader word valid.
REQ-009 Port: ld_data  input  32  program-loader word.
REQ-010 Port: ld_ready  output  1  loader may present a word.
REQ-011 Port: ld_done  input  1  loader finished; pulse.
REQ-012 Port: run  output  1  core may fetch and execute; high only in RUN.
REQ-013 Port: oob  output  1  sticky out-of-range access flag.

Function
REQ-014 The FSM SHALL have two states: LOAD (entered on reset) and RUN.
REQ-015 LOAD SHALL hold ld_ready=1 while ld_ptr<DEPTH, and 0 when ld_ptr=DEPTH (full).
REQ-016 In LOAD, ld_valid&ld_ready SHALL write ld_data to word ld_ptr and increment ld_ptr by 1; ld_valid while full SHALL be ignored, with no wrap.
REQ-017 In LOAD, ld_done SHALL move the FSM to RUN on the next edge; a ld_valid in the same cycle SHALL still be written.
REQ-018 In LOAD, pipeline wren SHALL be ignored, and rddata SHALL hold 0.
REQ-019 In RUN, ld_ready SHALL be 0, and ld_valid/ld_done SHALL be ignored; the FSM SHALL leave RUN only on rst.
REQ-020 In RUN, rddata SHALL equal mem[addr] sampled at the previous edge (1-cycle latency), every cycle, independent of wren.
REQ-021 In RUN, wren with addr<DEPTH SHALL write wrdata to mem[addr] at that edge.
REQ-022 A same-cycle read and write to one address SHALL return the old data (read-first), unless REQ-027 applies.
REQ-023 addr>=DEPTH in RUN SHALL produce rddata=0 next cycle, SHALL suppress any write, and SHALL set oob; oob SHALL clear only on rst.
REQ-024 Only addr[log2(DEPTH)-1:0] SHALL index the array after the range check.

Reset
REQ-025 On rst: state=LOAD, ld_ptr=0, rddata=0, ld_ready=1, run=0, oob=0; array contents SHALL be preserved.
REQ-026 rst asserted mid-load or mid-run SHALL take effect at the next edge and abort any pending write in that cycle.

Configuration
REQ-027 With MEM_RDBYPASS_EN defined: a RUN-state write and read to the same in-range address in one cycle SHALL return wrdata on rddata next cycle. Without it: read-first per REQ-022.

Structure
REQ-028 Shared package mips_mem_pkg SHALL hold the DEPTH default, the state enum (LOAD, RUN), and the word width constant (32).
REQ-029 The array SHALL be a sub-module mem_array (single-port, synchronous read, write enable). The FSM, pointer, range check and bypass SHALL stay in mem_responder.

Verification
REQ-030 Reset, load 4 words 0x11,0x22,0x33,0x44, pulse ld_done -> run=1 on the following cycle; addr=2 -> rddata=0x33 one cycle later.
REQ-031 RUN, wren=1 addr=5 wrdata=0xDEADBEEF, then addr=5 read -> rddata=0xDEADBEEF; same-cycle read/write of addr 5 with 0x1 -> 0xDEADBEEF (no macro) or 0x1 (MEM_RDBYPASS_EN).
REQ-032 DEPTH=16, 17 loader words offered -> ld_ready drops after 16 accepts; word 0 unchanged by word 17.
REQ-033 RUN, addr=DEPTH with wren=1 -> rddata=0, oob=1 stays set; mem[0] unchanged; rst -> oob=0.
REQ-034 In RUN, pulse rst -> state LOAD, run=0, ld_ptr=0, rddata=0; previously loaded words read back unchanged after a new ld_done.
REQ-035 In LOAD, wren=1 addr=0 wrdata=0xFF -> ignored; after RUN, addr=0 returns the loaded value.
